// File: rtl/z80_bus_tracer_pkg.sv
// Shared definitions for the Z80 bus tracer: bus widths, transaction type codes, entry layout.
package z80_bus_tracer_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned TYPE_W    = 3;
  localparam int unsigned NUM_TYPES = 5;
  localparam int unsigned HDR_W     = TYPE_W + ADDR_W + DATA_W;
  localparam int unsigned DROP_W    = 8;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_MEM_RD  = 3'd0,
    TYPE_MEM_WR  = 3'd1,
    TYPE_IO_RD   = 3'd2,
    TYPE_IO_WR   = 3'd3,
    TYPE_IRQ_ACK = 3'd4
  } trace_type_e;

  // Entry layout, MSB first: {type, addr, data, ts}
  function automatic int unsigned entry_w(input int unsigned ts_w);
    return HDR_W + ts_w;
  endfunction

  function automatic logic is_write_type(input logic [TYPE_W-1:0] t);
    return (t == TYPE_MEM_WR) || (t == TYPE_IO_WR);
  endfunction

endpackage

// File: rtl/z80_bus_tracer_ring_buf.sv
// Trace ring buffer: FWFT read, push/pop with optional overwrite-oldest, sticky loss tracking.
module trace_ring_buf
  import z80_bus_tracer_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned ENTRY_W = 43
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic [2:0]               extra_drops,
  input  logic                     pop,
  input  logic                     wrap_mode,
  output logic                     valid,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic       full, empty, do_pop, do_write, overwrite, lost;
  logic [2:0] n_lost;
  logic [DROP_W:0] drop_sum;

  // A pop in the same cycle frees a slot, so a full buffer only loses when nobody reads.
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    empty     = (count == '0);
    do_pop    = pop & ~empty;
    lost      = push & full & ~do_pop;
    overwrite = lost & wrap_mode;
    do_write  = push & (~full | do_pop | wrap_mode);
    n_lost    = 3'(lost) + extra_drops;
    drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(n_lost);
  end

  always_ff @(posedge clk) begin
    if (do_write && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop || overwrite) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_write & ~overwrite) - CNT_W'(do_pop);
      if (n_lost != 3'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
      end
    end
  end

  assign valid   = ~empty;
  assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/z80_bus_tracer.sv
// Z80 bus tracer: strobe edge capture, priority select, address/type windows, timestamp.
module z80_bus_tracer
  import z80_bus_tracer_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned NUM_FILTERS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           z80_addr,
  input  logic [DATA_W-1:0]           z80_do,
  input  logic [DATA_W-1:0]           z80_di,
  input  logic                        z80_mem_rd,
  input  logic                        z80_mem_wr,
  input  logic                        z80_io_rd,
  input  logic                        z80_io_wr,
  input  logic                        z80_irq_rd,
  input  logic                        enable,
  input  logic                        wrap_mode,
  input  logic                        clear,
  input  logic [NUM_FILTERS-1:0]      flt_en,
  input  logic [16*NUM_FILTERS-1:0]   flt_lo,
  input  logic [16*NUM_FILTERS-1:0]   flt_hi,
  input  logic [5*NUM_FILTERS-1:0]    flt_type,
  output logic                        trace_valid,
  output logic [HDR_W+TS_W-1:0]       trace_data,
  input  logic                        trace_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_cnt
);

  localparam int unsigned ENTRY_W = entry_w(TS_W);

  logic [NUM_TYPES-1:0] strobe, strobe_q, fall;
  logic [ADDR_W-1:0]    addr_q [NUM_TYPES];
  logic [DATA_W-1:0]    data_q [NUM_TYPES];
  logic [TS_W-1:0]      ts_q;

  logic [TYPE_W-1:0]    sel;
  logic                 found;
  logic [2:0]           n_fall;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic [NUM_FILTERS-1:0] hit;
  logic                 pass, push;
  logic [2:0]           extra_drops;
  logic [ENTRY_W-1:0]   push_data;

  assign strobe = {z80_irq_rd, z80_io_wr, z80_io_rd, z80_mem_wr, z80_mem_rd};
  assign fall   = strobe_q & ~strobe;

  // Track each strobe independently; the last high cycle's addr/data is what gets committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= '0;
      ts_q     <= '0;
      for (int i = 0; i < int'(NUM_TYPES); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      strobe_q <= strobe;
      ts_q     <= clear ? '0 : ts_q + TS_W'(1);
      for (int i = 0; i < int'(NUM_TYPES); i++) begin
        if (strobe[i]) begin
          addr_q[i] <= z80_addr;
          data_q[i] <= is_write_type(TYPE_W'(i)) ? z80_do : z80_di;
        end
      end
    end
  end

  // Lowest type code wins when several strobes fall together.
  always_comb begin
    sel    = '0;
    found  = 1'b0;
    n_fall = '0;
    for (int i = 0; i < int'(NUM_TYPES); i++) begin
      if (fall[i]) begin
        n_fall = n_fall + 3'd1;
        if (!found) begin
          sel   = TYPE_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign sel_addr = addr_q[sel];
  assign sel_data = data_q[sel];

  for (genvar g = 0; g < int'(NUM_FILTERS); g++) begin : g_win
    logic [ADDR_W-1:0] lo, hi;
    logic [NUM_TYPES-1:0] tmask;
    assign lo     = flt_lo[16*g +: 16];
    assign hi     = flt_hi[16*g +: 16];
    assign tmask  = flt_type[5*g +: 5];
    assign hit[g] = flt_en[g] & (sel_addr >= lo) & (sel_addr <= hi) & tmask[sel];
  end

  assign pass        = ~(|flt_en) | (|hit);
  assign push        = found & enable & pass;
  assign extra_drops = (found && enable) ? n_fall - 3'd1 : 3'd0;
  assign push_data   = {sel, sel_addr, sel_data, ts_q};

  trace_ring_buf #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .push        (push),
    .push_data   (push_data),
    .extra_drops (extra_drops),
    .pop         (trace_ready),
    .wrap_mode   (wrap_mode),
    .valid       (trace_valid),
    .rd_data     (trace_data),
    .count       (count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Self-checking bench for z80_bus_tracer against a queue-based transaction model.
module tb_z80_bus_tracer;

  localparam int DEPTH = 4;
  localparam int TS_W  = 16;
  localparam int NF    = 2;
  localparam int EW    = 27 + TS_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     z80_addr;
  logic [7:0]      z80_do, z80_di;
  logic            z80_mem_rd, z80_mem_wr, z80_io_rd, z80_io_wr, z80_irq_rd;
  logic            enable, wrap_mode, clear;
  logic [NF-1:0]   flt_en;
  logic [16*NF-1:0] flt_lo, flt_hi;
  logic [5*NF-1:0] flt_type;
  logic            trace_valid;
  logic [EW-1:0]   trace_data;
  logic            trace_ready;
  logic [2:0]      count;
  logic            overflow;
  logic [7:0]      drop_cnt;

  z80_bus_tracer #(.DEPTH(DEPTH), .TS_W(TS_W), .NUM_FILTERS(NF)) dut (
    .clk(clk), .rst_n(rst_n), .z80_addr(z80_addr), .z80_do(z80_do), .z80_di(z80_di),
    .z80_mem_rd(z80_mem_rd), .z80_mem_wr(z80_mem_wr), .z80_io_rd(z80_io_rd),
    .z80_io_wr(z80_io_wr), .z80_irq_rd(z80_irq_rd), .enable(enable), .wrap_mode(wrap_mode),
    .clear(clear), .flt_en(flt_en), .flt_lo(flt_lo), .flt_hi(flt_hi), .flt_type(flt_type),
    .trace_valid(trace_valid), .trace_data(trace_data), .trace_ready(trace_ready),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [4:0]    m_prev;
  logic [15:0]   m_addr [5];
  logic [7:0]    m_data [5];
  logic [15:0]   m_ts;
  logic [EW-1:0] mq [$];
  logic          m_ovf;
  int            m_drops;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit m_pass(input int t, input logic [15:0] a);
    if (flt_en == '0) return 1'b1;
    for (int w = 0; w < NF; w++)
      if (flt_en[w] && a >= flt_lo[16*w +: 16] && a <= flt_hi[16*w +: 16] && flt_type[5*w + t])
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [EW-1:0] m_front();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic set_strobes(input logic [4:0] s);
    {z80_irq_rd, z80_io_wr, z80_io_rd, z80_mem_wr, z80_mem_rd} = s;
  endtask

  task automatic model_reset();
    m_prev = '0; m_ts = '0; m_ovf = 1'b0; m_drops = 0;
    mq.delete();
  endtask

  // One clock: apply the spec's commit/filter/buffer rules to the current inputs, then advance.
  task automatic tick();
    logic [4:0] cur, fall;
    bit do_pop, lost;
    int k, extras;
    cur    = {z80_irq_rd, z80_io_wr, z80_io_rd, z80_mem_wr, z80_mem_rd};
    fall   = m_prev & ~cur;
    do_pop = trace_ready && (mq.size() > 0);
    if (clear) begin
      model_reset();
    end else begin
      lost = 1'b0; extras = 0; k = -1;
      if (do_pop) void'(mq.pop_front());
      if (fall != 0 && enable) begin
        for (int i = 4; i >= 0; i--) if (fall[i]) begin k = i; extras++; end
        extras--;
        if (m_pass(k, m_addr[k])) begin
          if (mq.size() == DEPTH) begin
            lost = 1'b1;
            if (wrap_mode) begin
              void'(mq.pop_front());
              mq.push_back({3'(k), m_addr[k], m_data[k], m_ts});
            end
          end else begin
            mq.push_back({3'(k), m_addr[k], m_data[k], m_ts});
          end
        end
      end
      if (extras + int'(lost) > 0) begin
        m_ovf = 1'b1;
        m_drops = (m_drops + extras + int'(lost) > 255) ? 255 : m_drops + extras + int'(lost);
      end
      m_ts = m_ts + 16'd1;
    end
    for (int i = 0; i < 5; i++) if (cur[i]) begin
      m_addr[i] = z80_addr;
      m_data[i] = (i == 1 || i == 3) ? z80_do : z80_di;
    end
    m_prev = cur;
    @(posedge clk); #1;
  endtask

  // Strobe type t for hold cycles, then the commit cycle.
  task automatic txn(input int t, input logic [15:0] a, input logic [7:0] d, input int hold);
    logic [4:0] s;
    s = '0; s[t] = 1'b1;
    z80_addr = a; z80_do = d; z80_di = d;
    set_strobes(s);
    repeat (hold) tick();
    set_strobes('0);
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", trace_valid); end
    n_checks++; if (trace_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h want=0", trace_data); end
    n_checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_flags got=%b/%0d want=0/0", overflow, drop_cnt); end
  endtask

  task automatic test_single_write();
    logic [15:0] ts_at;
    z80_addr = 16'hC123; z80_do = 8'h5A; z80_di = 8'h00;
    set_strobes(5'b00010);
    repeat (3) tick();
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL wr_early_valid got=%b want=0", trace_valid); end
    set_strobes('0);
    ts_at = m_ts;
    tick();
    n_checks++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid got=%b want=1", trace_valid); end
    n_checks++; if (trace_data !== {3'd1, 16'hC123, 8'h5A, ts_at}) begin n_fail++; $display("FAIL wr_entry got=%h want=%h", trace_data, {3'd1, 16'hC123, 8'h5A, ts_at}); end
    n_checks++; if (ts_at !== 16'd3) begin n_fail++; $display("FAIL wr_ts got=%0d want=3", ts_at); end
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL wr_pop_valid got=%b want=0", trace_valid); end
  endtask

  task automatic test_filter();
    do_clear();
    flt_en = 2'b01;
    flt_lo = {16'hFFFF, 16'hC000}; flt_hi = {16'h0000, 16'hDFFF};
    flt_type = {5'b11111, 5'b00011};
    txn(0, 16'h0100, 8'h11, 1);
    txn(0, 16'hC000, 8'h22, 2);
    txn(3, 16'h0001, 8'h33, 1);
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL flt_count got=%0d want=1", count); end
    n_checks++; if (trace_data[EW-1 -: 27] !== {3'd0, 16'hC000, 8'h22}) begin n_fail++; $display("FAIL flt_entry got=%h want=%h", trace_data[EW-1 -: 27], {3'd0, 16'hC000, 8'h22}); end
    flt_en = '0;
  endtask

  task automatic test_overflow(input logic wrap);
    do_clear();
    wrap_mode = wrap;
    for (int i = 0; i < 6; i++) txn(1, 16'h1000 + 16'(i), 8'(i), 1);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf%0d_count got=%0d want=4", wrap, count); end
    n_checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf%0d_flags got=%b/%0d want=1/2", wrap, overflow, drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (trace_data[TS_W+8 +: 16] !== 16'h1000 + 16'(wrap ? i + 2 : i)) begin
        n_fail++; $display("FAIL ovf%0d_entry%0d got=%h want=%h", wrap, i, trace_data[TS_W+8 +: 16], 16'h1000 + 16'(wrap ? i + 2 : i));
      end
      trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    end
    wrap_mode = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < 4; i++) txn(0, 16'h2000 + 16'(i), 8'(i), 1);
    z80_addr = 16'h2004; set_strobes(5'b00001); tick();
    set_strobes('0); trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fpp_count got=%0d want=4", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got=%b want=0", overflow); end
    n_checks++; if (trace_data[TS_W+8 +: 16] !== 16'h2001) begin n_fail++; $display("FAIL fpp_head got=%h want=2001", trace_data[TS_W+8 +: 16]); end
    trace_ready = 1'b1; repeat (3) tick(); trace_ready = 1'b0;
    n_checks++; if (trace_data[TS_W+8 +: 16] !== 16'h2004) begin n_fail++; $display("FAIL fpp_tail got=%h want=2004", trace_data[TS_W+8 +: 16]); end
  endtask

  task automatic test_simultaneous();
    do_clear();
    z80_addr = 16'h0042; z80_di = 8'hC7;
    set_strobes(5'b10100); repeat (2) tick();
    set_strobes('0); tick();
    n_checks++; if (count !== 3'd1 || trace_data[EW-1 -: 3] !== 3'd2) begin n_fail++; $display("FAIL sim_entry got=%0d/%0d want=1/2", count, trace_data[EW-1 -: 3]); end
    n_checks++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL sim_drop got=%0d/%b want=1/1", drop_cnt, overflow); end
    for (int i = 0; i < 303; i++) txn(1, 16'(i), 8'(i), 1);
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat got=%0d want=255", drop_cnt); end
  endtask

  task automatic test_clear_push();
    z80_addr = 16'h3000; set_strobes(5'b00001); tick();
    set_strobes('0); clear = 1'b1; tick(); clear = 1'b0;
    n_checks++; if (count !== 3'd0 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL clr_count got=%0d/%b want=0/0", count, trace_valid); end
    n_checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL clr_drop got=%0d/%b want=0/0", drop_cnt, overflow); end
    txn(1, 16'h3001, 8'h99, 1);
    n_checks++; if (trace_data[TS_W-1:0] !== 16'd1) begin n_fail++; $display("FAIL clr_ts got=%0d want=1", trace_data[TS_W-1:0]); end
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    z80_addr = 16'h4000; z80_di = 8'h44; set_strobes(5'b00001);
    repeat (2) tick();
    rst_n = 1'b0; set_strobes('0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (count !== 3'd0 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid got=%0d/%b want=0/0", count, trace_valid); end
  endtask

  task automatic test_random();
    logic [4:0] s;
    for (int w = 0; w < NF; w++) begin
      flt_lo[16*w +: 16] = 16'($urandom_range(0, 16'h8000));
      flt_hi[16*w +: 16] = 16'($urandom_range(16'h4000, 16'hFFFF));
      flt_type[5*w +: 5] = 5'($urandom);
    end
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) begin wrap_mode = 1'($urandom); flt_en = 2'($urandom); end
      s = '0;
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 3) == 0) s[i] = 1'b1;
      set_strobes(s);
      z80_addr = 16'($urandom); z80_do = 8'($urandom); z80_di = 8'($urandom);
      trace_ready = ($urandom_range(0, 2) == 0);
      enable = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 60) == 0);
      tick();
      n_checks++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, mq.size()); end
      n_checks++; if (trace_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b", c, trace_valid); end
      n_checks++; if (trace_data !== m_front()) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, trace_data, m_front()); end
      n_checks++; if (overflow !== m_ovf || drop_cnt !== 8'(m_drops)) begin n_fail++; $display("FAIL rnd_drop c=%0d got=%b/%0d want=%b/%0d", c, overflow, drop_cnt, m_ovf, m_drops); end
    end
    set_strobes('0); trace_ready = 1'b0; clear = 1'b0; enable = 1'b1; flt_en = '0;
  endtask

  initial begin
    rst_n = 1'b0; z80_addr = '0; z80_do = '0; z80_di = '0; set_strobes('0);
    enable = 1'b1; wrap_mode = 1'b0; clear = 1'b0; trace_ready = 1'b0;
    flt_en = '0; flt_lo = '0; flt_hi = '0; flt_type = '0;
    test_reset();
    test_single_write();
    test_filter();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_full_push_pop();
    test_simultaneous();
    test_clear_push();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
